regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the RV32I register file and shares it between NUM_REQ writeback requesters (e.g. ALU, load unit) using round-robin arbitration.
- Keeps a per-register busy scoreboard, set at instruction issue and cleared when the write lands, so decode can detect RAW and WAW hazards.
- Sits between the writeback sources and the register file write inputs (regwrite, rd, write_data).

Parameters:
- NUM_REQ, 2, number of writeback requesters.
- XLEN, `INSTRUCTION_SIZE (32), data width.
- REG_COUNT, `REG_COUNT (32), number of architectural registers. AW = $clog2(REG_COUNT).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero).
- req_rd  in  NUM_REQ*AW  destination register, packed; requester i uses slice i.
- req_data  in  NUM_REQ*XLEN  write data, packed.
- issue_valid  in  1  instruction issuing with a destination register.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_ready  out  1  issue accepted (no WAW hazard).
- rs1, rs2  in  AW  source registers being decoded.
- rs1_busy, rs2_busy  out  1  source has a pending write.
- rf_regwrite  out  1  to the register file regwrite input.
- rf_rd  out  AW  to the register file rd input.
- rf_write_data  out  XLEN  to the register file write_data input.

Behaviour:
- Reset (async, rst_n=0): rf_regwrite=0, rf_rd=0, rf_write_data=0, busy[all]=0, rr_ptr=0. Pending writes are dropped; the system resets the register file at the same time.
- Arbitration is combinational. Search starts at rr_ptr and wraps modulo NUM_REQ. The first requester with req_valid=1 gets req_ready=1; all others get 0. If no requester is valid, req_ready=0.
- Handshake: a transfer occurs when req_valid && req_ready. Requesters hold valid, rd and data stable until ready. The grant never depends on ready feedback.
- After a transfer by requester g, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr is unchanged.
- Output stage is registered. A transfer at edge T drives rf_regwrite=1, rf_rd and rf_write_data during cycle T+1. The register file writes at the end of T+1. With no transfer, rf_regwrite=0 and rf_rd/rf_write_data hold their values.
- rd=0 request: handshake completes and rr_ptr advances, but rf_regwrite stays 0 (x0 is never written).
- Scoreboard:
  - busy[r] clears at the edge ending the cycle in which rf_regwrite=1 with rf_rd=r.
  - busy[issue_rd] sets on an edge where issue_valid && issue_ready && issue_rd!=0.
  - Simultaneous set and clear of the same r: set wins.
  - busy[0] is always 0.
- issue_ready = !busy[issue_rd]. This is combinational and conservative: a same-cycle clear does not raise it. issue_rd=0 always gives ready.
- rsX_busy = busy[rsX], combinational.
- Writes to a register that is not busy (e.g. an untracked CSR path) are allowed; busy is unaffected unless the set-wins rule applies.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined:
  - Adds ports rs1_fwd_valid, rs2_fwd_valid (1 bit) and rs1_fwd_data, rs2_fwd_data (XLEN).
  - rsX_fwd_valid=1 and rsX_fwd_data=rf_write_data when rf_regwrite=1 && rf_rd==rsX && rsX!=0.
  - rsX_busy is masked to 0 in that same cycle.
- Undefined: these ports are absent, and rsX_busy stays 1 through the output-stage cycle. Consumers read the register file from cycle T+2.

Decomposition:
- Shared package (RISCV_PKG.vh): `REG_COUNT, `INSTRUCTION_SIZE; add `RF_WB_REQ_NUM (default requester count).
- One sub-module: rr_arbiter, a generic N-way round-robin with inputs valid[N] and ptr, output grant one-hot, and encoded grant index. The scoreboard and output stage stay in the top module.

Test Plan:
- Single write: req_valid=01, rd=5, data=0xDEADBEEF at edge T -> req_ready=01 in that cycle; rf_regwrite=1, rf_rd=5, rf_write_data=0xDEADBEEF in T+1; rf_regwrite=0 in T+2.
- Contention: both requesters valid for 4 cycles, rr_ptr=0 -> grants alternate 01,10,01,10. A requester dropping valid lets the other win every cycle.
- Scoreboard:
  - issue rd=7 -> rs1=7 gives rs1_busy=1, and issue_ready=0 for a second issue of rd=7.
  - Writeback of rd=7 -> busy clears after the output cycle.
  - Issue rd=7 in the same cycle as that clear -> busy remains 1.
- x0: request rd=0 -> ready=1, rf_regwrite stays 0, rr_ptr advances. issue rd=0 -> issue_ready=1 and no busy bit is set.
- Async reset mid-transfer: drop rst_n between edges with rf_regwrite=1 and busy[3]=1 -> outputs and busy go 0 immediately, no clock needed. After release the first grant goes to requester 0.
- RF_WB_BYPASS_EN: rs2=9 while rf_regwrite=1, rf_rd=9, data=0x12345678 -> rs2_fwd_valid=1, rs2_fwd_data=0x12345678, rs2_busy=0. Without the macro -> rs2_busy=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Supplies the architectural defaults (register count, data width,
// writeback requester count) and the round-robin pointer helper.
`ifndef REG_COUNT
`define REG_COUNT 32
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif
`ifndef RF_WB_REQ_NUM
`define RF_WB_REQ_NUM 2
`endif

package regfile_wb_arbiter_pkg;

    localparam int RF_REG_COUNT = `REG_COUNT;
    localparam int RF_XLEN      = `INSTRUCTION_SIZE;
    localparam int RF_NUM_REQ   = `RF_WB_REQ_NUM;

    // Next round-robin start position after requester idx was served.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Generic N-way round-robin arbiter (module rr_arbiter).
// Searches from ptr upward, wrapping modulo N; the first valid input wins.
// Purely combinational: the grant never depends on any ready feedback.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    // Scan from the lowest priority to the highest so the last hit
    // (the candidate nearest ptr) is the one that sticks.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with busy scoreboard.
// Shares the single register-file write port among NUM_REQ writeback
// sources (round-robin), registers the winning write for one cycle, and
// tracks pending destination registers for RAW/WAW hazard detection.
// Optional macro RF_WB_BYPASS_EN adds forwarding of the output-stage write
// to the rs1/rs2 decode ports and masks their busy flags in that cycle.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = RF_NUM_REQ,
    parameter int XLEN      = RF_XLEN,
    parameter int REG_COUNT = RF_REG_COUNT,
    localparam int AW       = $clog2(REG_COUNT),
    localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*AW-1:0]   req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    output logic                    issue_ready,
    input  logic [AW-1:0]           rs1,
    input  logic [AW-1:0]           rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    rf_regwrite,
    output logic [AW-1:0]           rf_rd,
    output logic [XLEN-1:0]         rf_write_data
`ifdef RF_WB_BYPASS_EN
    ,
    output logic                    rs1_fwd_valid,
    output logic                    rs2_fwd_valid,
    output logic [XLEN-1:0]         rs1_fwd_data,
    output logic [XLEN-1:0]         rs2_fwd_data
`endif
);

    logic [AW-1:0]        rd_arr   [NUM_REQ];
    logic [XLEN-1:0]      data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   grant;
    logic [IW-1:0]        grant_idx;
    logic                 grant_any;
    logic [IW-1:0]        rr_ptr_reg;
    logic [AW-1:0]        sel_rd;
    logic [XLEN-1:0]      sel_data;
    logic                 sel_write;
    logic                 rf_regwrite_reg;
    logic [AW-1:0]        rf_rd_reg;
    logic [XLEN-1:0]      rf_write_data_reg;
    logic [REG_COUNT-1:0] busy_reg;
    logic [REG_COUNT-1:0] busy_next;

    // Unpack the per-requester destination and data slices.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign rd_arr[gi]   = req_rd[gi*AW +: AW];
            assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
        end
    endgenerate

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .valid     (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Grant is the ready; a transfer happens whenever anyone is granted.
    assign req_ready = grant;
    assign sel_rd    = rd_arr[grant_idx];
    assign sel_data  = data_arr[grant_idx];
    // x0 transfers complete the handshake but never reach the register file.
    assign sel_write = grant_any && (sel_rd != '0);

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (grant_any) begin
            rr_ptr_reg <= IW'(rr_next(int'(grant_idx), NUM_REQ));
        end
    end

    // Output stage: one-cycle registered write towards the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_regwrite_reg   <= 1'b0;
            rf_rd_reg         <= '0;
            rf_write_data_reg <= '0;
        end else begin
            rf_regwrite_reg <= sel_write;
            if (sel_write) begin
                rf_rd_reg         <= sel_rd;
                rf_write_data_reg <= sel_data;
            end
        end
    end

    assign rf_regwrite   = rf_regwrite_reg;
    assign rf_rd         = rf_rd_reg;
    assign rf_write_data = rf_write_data_reg;

    // Issue is refused while the destination still has a write pending;
    // a clear happening this cycle is deliberately not looked through.
    assign issue_ready = !busy_reg[issue_rd];

    // Scoreboard next state: clear on landing write, then set on issue so
    // that a simultaneous set and clear of the same register leaves it busy.
    always_comb begin
        busy_next = busy_reg;
        if (rf_regwrite_reg) begin
            busy_next[rf_rd_reg] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic rs1_hit;
    logic rs2_hit;

    // Forward the value currently being written so decode need not wait.
    assign rs1_hit       = rf_regwrite_reg && (rf_rd_reg == rs1) && (rs1 != '0);
    assign rs2_hit       = rf_regwrite_reg && (rf_rd_reg == rs2) && (rs2 != '0);
    assign rs1_fwd_valid = rs1_hit;
    assign rs2_fwd_valid = rs2_hit;
    assign rs1_fwd_data  = rf_write_data_reg;
    assign rs2_fwd_data  = rf_write_data_reg;
    assign rs1_busy      = busy_reg[rs1] && !rs1_hit;
    assign rs2_busy      = busy_reg[rs2] && !rs2_hit;
`else
    // Without forwarding, a source stays busy through the output-stage cycle.
    assign rs1_busy = busy_reg[rs1];
    assign rs2_busy = busy_reg[rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (2 requesters,
// 32-bit data, 32 registers). Follows RF_WB_BYPASS_EN when it is defined.
module tb_regfile_wb_arbiter;

`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_rd;
    logic [63:0] req_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_regwrite;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
`ifdef RF_WB_BYPASS_EN
    logic        rs1_fwd_valid;
    logic        rs2_fwd_valid;
    logic [31:0] rs1_fwd_data;
    logic [31:0] rs2_fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rf_regwrite   (rf_regwrite),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data)
`ifdef RF_WB_BYPASS_EN
        ,
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_data  (rs2_fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [1:0]  e_ready;
        logic        e_iready;
        logic        e_rs1b;
        logic        e_rs2b;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rv, input logic [4:0] rd0, input logic [4:0] rd1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic iv,
                         input logic [4:0] ird, input logic [4:0] s1, input logic [4:0] s2);
        req_valid   = rv;
        req_rd      = {rd1, rd0};
        req_data    = {d1, d0};
        issue_valid = iv;
        issue_rd    = ird;
        rs1         = s1;
        rs2         = s2;
    endtask

    initial begin
        // rv, rd0, rd1, d0, d1, iv, ird, rs1, rs2 | ready, iready, rs1b, rs2b | we, rd, data after edge
        vecs[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        vecs[2]  = '{2'b10, 5'd0, 5'd2, 32'h0, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22};
        vecs[3]  = '{2'b11, 5'd3, 5'd4, 32'h30, 32'h40, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h30};
        vecs[4]  = '{2'b11, 5'd3, 5'd4, 32'h30, 32'h40, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h40};
        vecs[5]  = '{2'b11, 5'd3, 5'd4, 32'h30, 32'h40, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h30};
        vecs[6]  = '{2'b11, 5'd3, 5'd4, 32'h30, 32'h40, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h40};
        vecs[7]  = '{2'b10, 5'd0, 5'd4, 32'h0, 32'h40, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h40};
        vecs[8]  = '{2'b10, 5'd0, 5'd4, 32'h0, 32'h41, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h41};
        vecs[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h41};
        vecs[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h41};
        vecs[11] = '{2'b01, 5'd7, 5'd0, 32'h77, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77};
        vecs[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd7, 5'd7, 5'd0, 2'b00, 1'b0, !BYP, 1'b0, 1'b0, 5'd7, 32'h77};
        vecs[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd7, 5'd7, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77};
        vecs[14] = '{2'b10, 5'd0, 5'd7, 32'h0, 32'h78, 1'b0, 5'd0, 5'd7, 5'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h78};
        vecs[15] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h78};
        vecs[16] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd7, 5'd7, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h78};
        vecs[17] = '{2'b01, 5'd0, 5'd0, 32'hAA, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h78};
        vecs[18] = '{2'b11, 5'd1, 5'd2, 32'h11, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22};
        vecs[19] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd7, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 32'h22};
        vecs[20] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h22};

        // Reset state
        rst_n = 1'b0;
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regwrite", 32'(rf_regwrite), 32'h0);
        chk("rst_rd", 32'(rf_rd), 32'h0);
        chk("rst_data", rf_write_data, 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sequence
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rv, vecs[i].rd0, vecs[i].rd1, vecs[i].d0, vecs[i].d1,
                  vecs[i].iv, vecs[i].ird, vecs[i].s1, vecs[i].s2);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_issue_ready", i), 32'(issue_ready), 32'(vecs[i].e_iready));
            chk($sformatf("v%0d_rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].e_rs1b));
            chk($sformatf("v%0d_rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].e_rs2b));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_regwrite", i), 32'(rf_regwrite), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_rd", i), 32'(rf_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_data", i), rf_write_data, vecs[i].e_data);
            $display("vec %0d ready=%b issue_ready=%b rs1_busy=%b rs2_busy=%b regwrite=%b rd=%0d data=%h",
                     i, req_ready, issue_ready, rs1_busy, rs2_busy, rf_regwrite, rf_rd, rf_write_data);
        end

        // Async reset mid-transfer with busy[3] set and a write in the output stage
        @(negedge clk);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7);
        @(negedge clk);
        drive(2'b01, 5'd5, 5'd0, 32'h55, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7);
        #1;
        chk("ar_busy3_set", 32'(rs1_busy), 32'h1);
        @(posedge clk);
        #2;
        chk("ar_pre_regwrite", 32'(rf_regwrite), 32'h1);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("ar_regwrite", 32'(rf_regwrite), 32'h0);
        chk("ar_rd", 32'(rf_rd), 32'h0);
        chk("ar_data", rf_write_data, 32'h0);
        chk("ar_busy3", 32'(rs1_busy), 32'h0);
        chk("ar_busy7", 32'(rs2_busy), 32'h0);
        $display("async reset regwrite=%b rd=%0d data=%h rs1_busy=%b rs2_busy=%b",
                 rf_regwrite, rf_rd, rf_write_data, rs1_busy, rs2_busy);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(2'b11, 5'd6, 5'd8, 32'h66, 32'h88, 1'b0, 5'd0, 5'd3, 5'd7);
        #1;
        chk("ar_first_grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("ar_first_rd", 32'(rf_rd), 32'd6);
        chk("ar_first_data", rf_write_data, 32'h66);
        $display("post reset grant ready=%b rd=%0d data=%h", req_ready, rf_rd, rf_write_data);

        // Output-stage visibility of a pending source (forwarding when enabled)
        @(negedge clk);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd3, 5'd9);
        @(negedge clk);
        drive(2'b10, 5'd0, 5'd9, 32'h0, 32'h12345678, 1'b0, 5'd0, 5'd3, 5'd9);
        #1;
        chk("fw_ready", 32'(req_ready), 32'h2);
        chk("fw_busy_pending", 32'(rs2_busy), 32'h1);
        @(negedge clk);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9);
        #1;
        chk("fw_regwrite", 32'(rf_regwrite), 32'h1);
        chk("fw_rs2_busy", 32'(rs2_busy), 32'(!BYP));
`ifdef RF_WB_BYPASS_EN
        chk("fw_rs2_valid", 32'(rs2_fwd_valid), 32'h1);
        chk("fw_rs2_data", rs2_fwd_data, 32'h12345678);
        chk("fw_rs1_valid", 32'(rs1_fwd_valid), 32'h0);
`endif
        $display("forward cycle regwrite=%b rd=%0d data=%h rs2_busy=%b",
                 rf_regwrite, rf_rd, rf_write_data, rs2_busy);
        @(negedge clk);
        #1;
        chk("fw_rs2_cleared", 32'(rs2_busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
